// File: rtl/nonce_sweep_scheduler.sv
// nonce_sweep_scheduler
// Hands consecutive nonces of a work item to a SHA-256 core, keeps at most
// MAX_INFLIGHT of them outstanding, and reports either the first golden
// nonce returned by the core or that the range was exhausted.
// Optional build macro: NONCE_SWEEP_STATS_EN adds the stat_hashes counter;
// without it stat_hashes is tied to zero.
module nonce_sweep_scheduler #(
   parameter int LOOP_LOG2    = 0,
   parameter int DIFFICULTY   = 2,
   parameter int MAX_INFLIGHT = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         work_valid,
   output logic         work_ready,
   input  logic [255:0] work_midstate,
   input  logic [95:0]  work_data,
   input  logic [31:0]  work_nonce_start,
   input  logic [31:0]  work_nonce_end,
   input  logic         abort,
   input  logic         core_ready,
   output logic         core_issue,
   output logic [31:0]  core_nonce,
   output logic [255:0] core_midstate,
   output logic [95:0]  core_data,
   input  logic         core_done,
   input  logic [31:0]  core_done_nonce,
   input  logic [31:0]  core_hash_hi,
   output logic         res_valid,
   input  logic         res_ready,
   output logic         res_found,
   output logic [31:0]  res_nonce,
   output logic [31:0]  stat_hashes
);

   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, REPORT} state_t;

   // A hit needs the top 4*DIFFICULTY bits of the hash word to be zero.
   localparam int         HIT_SHIFT = 32 - 4 * DIFFICULTY;
   localparam logic [3:0] MAX_CNT   = 4'(MAX_INFLIGHT);

   // Reject unusable parameter values at elaboration time.
   if (LOOP_LOG2 < 0 || DIFFICULTY < 1 || DIFFICULTY > 8 ||
       MAX_INFLIGHT < 1 || MAX_INFLIGHT > 15) begin : g_bad_param
      $error("nonce_sweep_scheduler: parameter out of legal range");
   end

   state_t         state, state_nxt;
   logic [3:0]     inflight;
   logic [31:0]    nonce;
   logic [31:0]    nonce_end;
   logic [31:0]    hit_nonce;
   logic [255:0]   midstate_q;
   logic [95:0]    data_q;
   logic           hit_flag;
   logic           abort_seen;
   logic           accept;
   logic           issue;
   logic           done_counted;
   logic           hit_now;

   // Returns for an empty pipeline (e.g. stray results after reset) are dropped.
   assign done_counted = core_done && (inflight != 4'd0);
   assign hit_now      = done_counted && !hit_flag &&
                         ((core_hash_hi >> HIT_SHIFT) == 32'd0);
   assign accept       = (state == IDLE) && work_valid;

   // Next-state and issue decision.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_nxt = state;
      issue     = 1'b0;
      case (state)
         IDLE: begin
            if (work_valid) state_nxt = SWEEP;
         end
         SWEEP: begin
            issue = core_ready && (inflight < MAX_CNT) && !hit_flag &&
                    !hit_now && !abort;
            if (abort || hit_now || (issue && nonce == nonce_end))
               state_nxt = DRAIN;
         end
         DRAIN: begin
            if (inflight == 4'd0) state_nxt = abort_seen ? IDLE : REPORT;
         end
         REPORT: begin
            if (res_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Latched work item: nonce cursor, end, midstate and block tail.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the wide work registers are reset too, so the core sees a
         // defined all-zero item before the first acceptance.
         nonce      <= 32'd0;
         nonce_end  <= 32'd0;
         midstate_q <= 256'd0;
         data_q     <= 96'd0;
      end else if (accept) begin
         nonce      <= work_nonce_start;
         nonce_end  <= work_nonce_end;
         midstate_q <= work_midstate;
         data_q     <= work_data;
      end else if (issue) begin
         nonce <= nonce + 32'd1;
      end
   end

   // Outstanding-nonce count; simultaneous issue and return cancel out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight <= 4'd0;
      end else begin
         case ({issue, done_counted})
            2'b10:   inflight <= inflight + 4'd1;
            2'b01:   inflight <= inflight - 4'd1;
            default: inflight <= inflight;
         endcase
      end
   end

   // First-hit capture and abort memory, both cleared on acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_flag   <= 1'b0;
         hit_nonce  <= 32'd0;
         abort_seen <= 1'b0;
      end else if (accept) begin
         hit_flag   <= 1'b0;
         hit_nonce  <= 32'd0;
         abort_seen <= 1'b0;
      end else begin
         if (hit_now) begin
            hit_flag  <= 1'b1;
            hit_nonce <= core_done_nonce;
         end
         if (state == SWEEP && abort) abort_seen <= 1'b1;
      end
   end

`ifdef NONCE_SWEEP_STATS_EN
   logic [31:0] hash_count;

   // Wrapping count of results accepted from the core.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            hash_count <= 32'd0;
      else if (done_counted) hash_count <= hash_count + 32'd1;
   end

   assign stat_hashes = hash_count;
`else
   assign stat_hashes = 32'd0;
`endif

   assign work_ready    = (state == IDLE);
   assign core_issue    = issue;
   assign core_nonce    = nonce;
   assign core_midstate = midstate_q;
   assign core_data     = data_q;
   assign res_valid     = (state == REPORT);
   assign res_found     = (state == REPORT) && hit_flag;
   assign res_nonce     = (state != REPORT) ? 32'd0 :
                          (hit_flag ? hit_nonce : nonce_end);

endmodule

// File: tb/tb_nonce_sweep_scheduler.sv
// Self-checking bench for nonce_sweep_scheduler.
// A latency-modelling core returns issued nonces in order; the reference
// model expects nonces start..end in sequence (mod 2^32), at most MAX_OUT
// outstanding, and a result equal to the first returned hit, else end.
module tb_nonce_sweep_scheduler;

   localparam int DIFF    = 2;
   localparam int MAX_OUT = 2;
   localparam int BUDGET  = 3000;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         work_valid, work_ready;
   logic [255:0] work_midstate;
   logic [95:0]  work_data;
   logic [31:0]  work_nonce_start, work_nonce_end;
   logic         abort, core_ready, core_issue;
   logic [31:0]  core_nonce;
   logic [255:0] core_midstate;
   logic [95:0]  core_data;
   logic         core_done;
   logic [31:0]  core_done_nonce, core_hash_hi;
   logic         res_valid, res_ready, res_found;
   logic [31:0]  res_nonce, stat_hashes;

   nonce_sweep_scheduler #(
      .LOOP_LOG2(0), .DIFFICULTY(DIFF), .MAX_INFLIGHT(MAX_OUT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .work_valid(work_valid), .work_ready(work_ready),
      .work_midstate(work_midstate), .work_data(work_data),
      .work_nonce_start(work_nonce_start), .work_nonce_end(work_nonce_end),
      .abort(abort), .core_ready(core_ready), .core_issue(core_issue),
      .core_nonce(core_nonce), .core_midstate(core_midstate),
      .core_data(core_data), .core_done(core_done),
      .core_done_nonce(core_done_nonce), .core_hash_hi(core_hash_hi),
      .res_valid(res_valid), .res_ready(res_ready), .res_found(res_found),
      .res_nonce(res_nonce), .stat_hashes(stat_hashes)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int stat_exp = 0;

   typedef struct {
      logic [31:0] nonce;
      int          due;
   } pend_t;

   function automatic bit is_hit(input logic [31:0] h);
      return h < (32'd1 << (32 - 4 * DIFF));
   endfunction

   function automatic logic [31:0] exp_stat();
`ifdef NONCE_SWEEP_STATS_EN
      return 32'(stat_exp);
`else
      return 32'd0;
`endif
   endfunction

   task automatic test_reset;
      work_valid = 0; work_midstate = '0; work_data = '0;
      work_nonce_start = '0; work_nonce_end = '0; abort = 0;
      core_ready = 0; core_done = 0; core_done_nonce = '0;
      core_hash_hi = '0; res_ready = 0;
      rst_n = 0;
      repeat (3) @(negedge clk);
      checks++;
      if (work_ready !== 1'b1 || core_issue !== 1'b0 || res_valid !== 1'b0 ||
          res_found !== 1'b0 || res_nonce !== 32'd0) begin
         errors++;
         $display("FAIL reset_ctrl: ready=%b issue=%b rv=%b rf=%b rn=%h, want 1 0 0 0 0",
                  work_ready, core_issue, res_valid, res_found, res_nonce);
      end
      checks++;
      if (core_nonce !== 32'd0 || core_midstate !== 256'd0 ||
          core_data !== 96'd0 || stat_hashes !== 32'd0) begin
         errors++;
         $display("FAIL reset_data: nonce=%h data=%h stat=%h, want all zero",
                  core_nonce, core_data, stat_hashes);
      end
      rst_n = 1;
      stat_exp = 0;
   endtask

   // One work item end to end. first_lat >= 0 overrides the latency of the
   // first issued nonce; abort_after >= 0 raises abort once that many issued.
   task automatic run_job(input string name, input logic [31:0] s,
                          input logic [31:0] e, input int lat_min,
                          input int lat_max, input int first_lat,
                          input int ready_pct, input int hit_pct,
                          input logic [31:0] fh0, input logic [31:0] fh1,
                          input int nfh, input int abort_after, input int hold);
      logic [255:0] ms;
      logic [95:0]  dt;
      logic [31:0]  next_exp, hit_nonce, h, exp_nonce;
      pend_t        pend[$];
      pend_t        p;
      int           cyc, issued, returned, last_due, abort_left, out_reg;
      int           lat, max_out, total, stab_err;
      int           order_err, extra_err, missed_err;
      bit           range_done, hit_seen, aborted, stopped, exp_issue;
      bit           saw_res, saw_idle, timeout, exp_found;

      ms = {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
      dt = {$urandom(), $urandom(), $urandom()};
      total = int'(e - s) + 1;

      @(negedge clk);
      work_midstate = ms; work_data = dt;
      work_nonce_start = s; work_nonce_end = e; work_valid = 1;
      core_done = 0; core_ready = 0; abort = 0; res_ready = 0;
      #1;
      checks++;
      if (work_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s accept: work_ready=%b, want 1", name, work_ready);
      end
      @(posedge clk);

      cyc = 0; issued = 0; returned = 0; last_due = 0; abort_left = 2;
      max_out = 0; order_err = 0; extra_err = 0; missed_err = 0;
      next_exp = s; hit_nonce = 0;
      range_done = 0; hit_seen = 0; aborted = 0;
      saw_res = 0; saw_idle = 0; timeout = 0;

      while (!saw_res && !saw_idle && !timeout) begin
         @(negedge clk);
         work_valid = 0;
         work_midstate = {8{$urandom()}};
         work_data = {3{$urandom()}};
         work_nonce_start = $urandom(); work_nonce_end = $urandom();
         out_reg = issued - returned;
         core_done = 0; core_done_nonce = $urandom(); core_hash_hi = $urandom();
         if (pend.size() > 0 && pend[0].due <= cyc) begin
            p = pend.pop_front();
            if ((nfh > 0 && p.nonce == fh0) || (nfh > 1 && p.nonce == fh1))
               h = 32'h00ABCDEF;
            else if (int'($urandom_range(99)) < hit_pct)
               h = ($urandom_range(3) == 0) ? 32'h00FFFFFF : ($urandom() & 32'h00FFFFFF);
            else if (hit_pct == 0)
               h = 32'hFFFFFFFF;
            else
               h = ($urandom_range(3) == 0) ? 32'h01000000 : ($urandom() | 32'h01000000);
            core_done = 1; core_done_nonce = p.nonce; core_hash_hi = h;
            returned++; stat_exp++;
            if (is_hit(h) && !hit_seen) begin
               hit_seen = 1; hit_nonce = p.nonce;
            end
         end
         core_ready = int'($urandom_range(99)) < ready_pct;
         abort = 0;
         if (abort_after >= 0 && issued >= abort_after && abort_left > 0) begin
            abort = 1; abort_left--; aborted = 1;
         end
         stopped = range_done || hit_seen || aborted;
         #1;
         exp_issue = !stopped && core_ready && (out_reg < MAX_OUT);
         if (core_issue !== exp_issue) begin
            if (core_issue === 1'b1) extra_err++;
            else missed_err++;
         end
         if (core_issue === 1'b1) begin
            if (core_nonce !== next_exp) order_err++;
            lat = (issued == 0 && first_lat >= 0) ? first_lat
                  : int'($urandom_range(lat_max, lat_min));
            last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            pend.push_back('{core_nonce, last_due});
            issued++;
            if (next_exp == e) range_done = 1;
            next_exp = next_exp + 32'd1;
         end
         if (issued - returned > max_out) max_out = issued - returned;
         if (res_valid === 1'b1) saw_res = 1;
         if (work_ready === 1'b1) saw_idle = 1;
         cyc++;
         if (cyc > BUDGET) timeout = 1;
      end
      abort = 0;

      checks++;
      if (timeout) begin
         errors++;
         $display("FAIL %s timeout: no result/idle after %0d cycles", name, cyc);
      end
      checks++;
      if (order_err != 0) begin
         errors++;
         $display("FAIL %s order: %0d out-of-sequence nonces, want 0", name, order_err);
      end
      checks++;
      if (extra_err != 0 || missed_err != 0) begin
         errors++;
         $display("FAIL %s issue_rule: extra=%0d missed=%0d, want 0 0",
                  name, extra_err, missed_err);
      end
      checks++;
      if (max_out > MAX_OUT) begin
         errors++;
         $display("FAIL %s inflight: max=%0d, limit %0d", name, max_out, MAX_OUT);
      end
      checks++;
      if (core_midstate !== ms || core_data !== dt) begin
         errors++;
         $display("FAIL %s latched_work: data=%h, want %h", name, core_data, dt);
      end
      checks++;
      if (stat_hashes !== exp_stat()) begin
         errors++;
         $display("FAIL %s stats: got %0d, want %0d", name, stat_hashes, exp_stat());
      end

      if (aborted) begin
         checks++;
         if (saw_res || !saw_idle || pend.size() != 0) begin
            errors++;
            $display("FAIL %s abort: res_seen=%0d idle=%0d pending=%0d, want 0 1 0",
                     name, saw_res, saw_idle, pend.size());
         end
      end else begin
         exp_found = hit_seen;
         exp_nonce = hit_seen ? hit_nonce : e;
         if (!hit_seen) begin
            checks++;
            if (issued != total) begin
               errors++;
               $display("FAIL %s count: issued %0d, want %0d", name, issued, total);
            end
         end
         checks++;
         if (res_valid !== 1'b1 || res_found !== exp_found ||
             res_nonce !== exp_nonce || work_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s result: rv=%b found=%b nonce=%h ready=%b, want 1 %b %h 0",
                     name, res_valid, res_found, res_nonce, work_ready,
                     exp_found, exp_nonce);
         end
         stab_err = 0;
         for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            abort = ($urandom_range(1) == 1);
            #1;
            if (res_valid !== 1'b1 || res_found !== exp_found ||
                res_nonce !== exp_nonce || work_ready !== 1'b0) stab_err++;
         end
         abort = 0;
         if (hold > 0) begin
            checks++;
            if (stab_err != 0) begin
               errors++;
               $display("FAIL %s hold: %0d unstable cycles of %0d, want 0",
                        name, stab_err, hold);
            end
         end
         res_ready = 1;
         @(posedge clk);
         @(negedge clk);
         res_ready = 0;
         #1;
         checks++;
         if (work_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s release: ready=%b rv=%b, want 1 0", name, work_ready, res_valid);
         end
      end
   endtask

   task automatic test_reset_mid_sweep;
      @(negedge clk);
      work_midstate = {8{$urandom()}}; work_data = {3{$urandom()}};
      work_nonce_start = 32'h1000; work_nonce_end = 32'h10FF;
      work_valid = 1; core_ready = 1;
      @(negedge clk);
      work_valid = 0;
      repeat (3) @(negedge clk);
      rst_n = 0;
      #1;
      checks++;
      if (work_ready !== 1'b1 || core_issue !== 1'b0 || res_valid !== 1'b0 ||
          stat_hashes !== 32'd0 || core_nonce !== 32'd0 || core_data !== 96'd0) begin
         errors++;
         $display("FAIL mid_reset: ready=%b issue=%b rv=%b stat=%0d nonce=%h, want 1 0 0 0 0",
                  work_ready, core_issue, res_valid, stat_hashes, core_nonce);
      end
      @(negedge clk);
      rst_n = 1;
      stat_exp = 0;
      core_done = 1; core_done_nonce = 32'h1001; core_hash_hi = 32'h0;
      repeat (3) @(negedge clk);
      core_done = 0;
      core_ready = 0;
      #1;
      checks++;
      if (stat_hashes !== 32'd0 || work_ready !== 1'b1 || core_issue !== 1'b0) begin
         errors++;
         $display("FAIL stray_done: stat=%0d ready=%b issue=%b, want 0 1 0",
                  stat_hashes, work_ready, core_issue);
      end
   endtask

   task automatic test_random;
      logic [31:0] s;
      int          lmin, ab;
      for (int i = 0; i < 8; i++) begin
         s = ($urandom_range(3) == 0) ? 32'hFFFFFFFF - $urandom_range(5) : $urandom();
         lmin = int'($urandom_range(3, 1));
         ab = ($urandom_range(4) == 0) ? int'($urandom_range(4)) : -1;
         run_job("random", s, s + $urandom_range(11), lmin,
                 lmin + int'($urandom_range(6)), -1, int'($urandom_range(100, 60)),
                 10, 32'h0, 32'h0, 0, ab, int'($urandom_range(3)));
      end
   endtask

   initial begin
      test_reset;
      run_job("no_hit",     32'h10, 32'h13, 10, 10, -1, 100, 0, 32'h0, 32'h0, 0, -1, 0);
      run_job("hit_0x11",   32'h10, 32'h13, 10, 10,  2, 100, 0, 32'h11, 32'h12, 2, -1, 0);
      run_job("wrap",       32'hFFFFFFFE, 32'h1, 1, 4, -1, 80, 0, 32'h0, 32'h0, 0, -1, 1);
      run_job("single",     32'h55, 32'h55, 2, 2, -1, 100, 0, 32'h0, 32'h0, 0, -1, 0);
      run_job("single_hit", 32'h7, 32'h7, 3, 3, -1, 100, 0, 32'h7, 32'h0, 1, -1, 0);
      run_job("max_inflt",  32'h100, 32'h10F, 10, 10, -1, 100, 0, 32'h0, 32'h0, 0, -1, 0);
      run_job("same_cycle", 32'h200, 32'h20F, 1, 1, -1, 100, 0, 32'h0, 32'h0, 0, -1, 0);
      run_job("abort",      32'h300, 32'h31F, 6, 6, -1, 100, 0, 32'h0, 32'h0, 0, 3, 0);
      run_job("hold5",      32'h400, 32'h402, 2, 3, -1, 100, 0, 32'h401, 32'h0, 1, -1, 5);
      test_reset_mid_sweep;
      run_job("post_reset", 32'h20, 32'h23, 2, 5, -1, 90, 0, 32'h0, 32'h0, 0, -1, 0);
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/nonce_sweep_scheduler.md
NONCE_SWEEP_SCHEDULER -- requirements
Module: nonce_sweep_scheduler

Interface
REQ-001 SHALL have parameter LOOP_LOG2, default 0, SHA-256 core unroll setting; informational only, sizes no logic.
REQ-002 SHALL have parameter DIFFICULTY, default 2, number of leading zero nibbles of hash word required for a hit; legal range 1..8.
REQ-003 SHALL have parameter MAX_INFLIGHT, default 4, maximum nonces issued to the core and not yet returned; legal range 1..15.
REQ-004 SHALL have ports, in this order:
 clk  in  1  rising-edge clock.
 rst_n  in  1  asynchronous active-low reset.
 work_valid  in  1  work item offered.
 work_ready  out  1  scheduler accepts work.
 work_midstate  in  256  midstate of work item.
 work_data  in  96  block tail of work item.
 work_nonce_start  in  32  first nonce.
 work_nonce_end  in  32  last nonce, inclusive.
 abort  in  1  level; abandon current work.
 core_ready  in  1  core can take a nonce this cycle.
 core_issue  out  1  nonce presented to core this cycle.
 core_nonce  out  32  nonce being issued.
 core_midstate  out  256  latched midstate.
 core_data  out  96  latched block tail.
 core_done  in  1  core returns a result.
 core_done_nonce  in  32  nonce of returned result.
 core_hash_hi  in  32  most-significant word of final hash.
 res_valid  out  1  result available.
 res_ready  in  1  result consumed.
 res_found  out  1  1 = golden nonce, 0 = range exhausted.
 res_nonce  out  32  golden nonce, or work_nonce_end when exhausted.
 stat_hashes  out  32  count of core_done pulses.

Function
REQ-005 SHALL use states IDLE, SWEEP, DRAIN, REPORT.
REQ-006 IDLE: work_ready=1, all other control outputs 0; on work_valid, latch midstate, data, start, end, set next nonce=start, clear hit flag, go to SWEEP next cycle.
REQ-007 work_ready SHALL be 0 in every state except IDLE.
REQ-008 SWEEP: core_issue=1 iff core_ready, in-flight count < MAX_INFLIGHT, hit flag clear, abort low; first issue possible the cycle after acceptance.
REQ-009 Each issue SHALL present current nonce on core_nonce and advance nonce by 1 mod 2^32; start > end sweeps through 0xFFFFFFFF, wraps to 0 and continues to end.
REQ-010 Issue of nonce equal to end SHALL move SWEEP to DRAIN; start == end issues exactly one nonce.
REQ-011 In-flight count SHALL increment on issue, decrement on core_done, stay unchanged when both occur in one cycle; core_done with count 0 SHALL be ignored.
REQ-012 Hit = core_done with top 4*DIFFICULTY bits of core_hash_hi zero; first hit latches core_done_nonce and sets hit flag; later hits ignored.
REQ-013 Hit flag set in SWEEP SHALL stop issuing that same cycle and move to DRAIN.
REQ-014 DRAIN: no issues; when in-flight count reaches 0 go to REPORT, or to IDLE if abort was seen since acceptance.
REQ-015 abort high in SWEEP SHALL move to DRAIN and suppress the result; abort in IDLE or REPORT SHALL be ignored.
REQ-016 REPORT: res_valid=1, res_found=hit flag, res_nonce=hit nonce or end; outputs stable until res_ready, then IDLE next cycle.
REQ-017 core_midstate and core_data SHALL hold latched values from acceptance until next acceptance.

Reset
REQ-018 rst_n low SHALL immediately force IDLE, in-flight 0, hit flag 0, nonce 0, latched work 0, res_valid 0, res_found 0, res_nonce 0, core_issue 0, stat_hashes 0; work_ready=1 while in IDLE.
REQ-019 Reset asserted mid-sweep SHALL discard work with no result; subsequent stray core_done ignored per REQ-011.

Configuration
REQ-020 With NONCE_SWEEP_STATS_EN defined, stat_hashes SHALL increment (wrapping) on every counted core_done; undefined, stat_hashes SHALL be constant 0 and counter logic absent.

Verification
REQ-021 DIFFICULTY=2, start=0x10, end=0x13, core returns hash_hi 0xFFFFFFFF -> issues 0x10..0x13 in order, res_found=0, res_nonce=0x13.
REQ-022 Same range, hash_hi 0x00ABCDEF for nonce 0x11 -> issuing stops, in-flight drains, res_found=1, res_nonce=0x11; later hit for 0x12 ignored.
REQ-023 start=0xFFFFFFFE, end=0x00000001 -> issues FFFFFFFE, FFFFFFFF, 0, 1, then DRAIN.
REQ-024 MAX_INFLIGHT=2, core_done delayed 10 cycles -> never >2 outstanding; issue and done same cycle keeps count.
REQ-025 abort raised after 3 issues -> no res_valid, return to IDLE after last core_done; rst_n pulse mid-sweep -> IDLE, work_ready=1, stat_hashes=0.
REQ-026 res_ready held low 5 cycles in REPORT -> res_valid, res_found, res_nonce stable, work_ready=0 throughout.
